// File: rtl/dac_wave_gen.sv
// Continuous waveform source for the DAC121S101 SPI master: a fixed-rate tick
// advances a 16-bit phase accumulator whose value is mapped to a 12-bit code.
module dac_wave_gen #(
  parameter int SAMPLE_DIV = 250,
  parameter int CNT_W      = 16
) (
  input  logic        i_Clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_wave_sel,
  input  logic [15:0] i_phase_inc,
  output logic        o_dac_start,
  output logic [11:0] o_dac_data,
  input  logic        i_dac_done,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_phase;

  logic        w_tick;
  logic        w_busy_eff;
  logic [11:0] w_sample;

  function automatic logic [11:0] wave_map(input logic [1:0] sel, input logic [15:0] p);
    logic [11:0] v;
    case (sel)
      2'd0:    v = p[15:4];
      2'd1:    v = p[15] ? ~p[14:3] : p[14:3];
      2'd2:    v = p[15] ? 12'hFFF : 12'h000;
      default: v = 12'h800;
    endcase
    return v;
  endfunction

  assign w_tick     = (r_cnt == LP_LAST);
  // A done in the tick cycle frees the master before the tick is judged.
  assign w_busy_eff = o_busy & ~i_dac_done;
  assign w_sample   = wave_map(i_wave_sel, r_phase);

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= '0;
      o_dac_start <= 1'b0;
      o_dac_data  <= '0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_dac_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state   <= S_RUN;
            r_phase   <= '0;
            r_cnt     <= LP_LAST;
            o_overrun <= 1'b0;
          end
        end
        S_RUN: begin
          o_busy <= w_busy_eff;
          if (!i_enable) begin
            r_state <= w_busy_eff ? S_DRAIN : S_IDLE;
          end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
              r_phase <= r_phase + i_phase_inc;
              if (w_busy_eff) begin
                o_overrun <= 1'b1;
              end else begin
                o_dac_data  <= w_sample;
                o_dac_start <= 1'b1;
                o_busy      <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (i_dac_done) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Bench for dac_wave_gen: SPI master stand-in with programmable done latency,
// a tick-schedule reference model compared every cycle, plus literal sequences.
module tb_dac_wave_gen;
  localparam int DIV = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [15:0] inc;
  logic        start;
  logic [11:0] data;
  logic        done;
  logic        busy;
  logic        ovr;

  int total = 0;
  int bad   = 0;
  int lat   = 70;
  bit pend  = 0;
  int rem   = 0;
  bit m_valid = 0;
  int m_mode = 0, m_n = 0, m_phase = 0, m_busy = 0, m_ovr = 0, m_start = 0, m_data = 0;
  logic [11:0] cap[$];

  always #20 clk = ~clk;

  dac_wave_gen #(.SAMPLE_DIV(DIV), .CNT_W(16)) dut (
    .i_Clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_wave_sel(sel),
    .i_phase_inc(inc), .o_dac_start(start), .o_dac_data(data),
    .i_dac_done(done), .o_busy(busy), .o_overrun(ovr)
  );

  function automatic int ref_wave(input int s, input int p);
    case (s)
      0:       return p / 16;
      1:       return (p < 32768) ? p / 8 : 4095 - (p - 32768) / 8;
      2:       return (p >= 32768) ? 4095 : 0;
      default: return 2048;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a sample is due every DIV cycles of running, counted from the first run cycle.
  initial forever begin
    int mode, n, ph, bz, ov, st, dt, s;
    @(posedge clk);
    mode = m_mode; n = m_n; ph = m_phase; bz = m_busy; ov = m_ovr; dt = m_data; st = 0;
    if (!rst_n) begin
      mode = 0; n = 0; ph = 0; bz = 0; ov = 0; dt = 0;
    end else if (mode == 0) begin
      if (en) begin mode = 1; n = 0; ph = 0; ov = 0; end
    end else if (mode == 1) begin
      if (done) bz = 0;
      if (!en) mode = bz ? 2 : 0;
      else begin
        if (n % DIV == 0) begin
          s  = ref_wave(int'(sel), ph);
          ph = (ph + int'(inc)) % 65536;
          if (bz != 0) ov = 1;
          else begin st = 1; dt = s; bz = 1; end
        end
        n++;
      end
    end else if (done) begin
      bz = 0; mode = 0;
    end
    m_mode = mode; m_n = n; m_phase = ph; m_busy = bz; m_ovr = ov; m_start = st; m_data = dt;
    m_valid = 1;
  end

  // SPI master stand-in: done pulses lat cycles after the start cycle.
  initial forever begin
    @(negedge clk);
    done = 1'b0;
    if (!rst_n) pend = 0;
    else if (start) begin pend = 1; rem = lat; end
    else if (pend) rem--;
    if (pend && rem == 0) begin done = 1'b1; pend = 0; end
  end

  // Per-cycle comparison against the reference, and capture of issued samples.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("start", int'(start), m_start);
      check("data",  int'(data),  m_data);
      check("busy",  int'(busy),  m_busy);
      check("overrun", int'(ovr), m_ovr);
    end
    if (start === 1'b1) cap.push_back(data);
  end

  task automatic run_ticks(input int n);
    cap.delete();
    en = 1'b1;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic stop_and_drain();
    en = 1'b0;
    repeat (250) @(negedge clk);
  endtask

  task automatic check_seq(input string name, input logic [11:0] e[$]);
    check({name, "_count"}, cap.size(), e.size());
    for (int i = 0; i < e.size() && i < cap.size(); i++)
      check(name, int'(cap[i]), int'(e[i]));
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (start === 1'b1) ok = 1;
    end
    check("wait_start_timeout", int'(ok), 1);
  endtask

  initial begin
    logic [11:0] e[$];
    int held;
    rst_n = 1'b0; en = 1'b0; sel = 2'd0; inc = 16'h0; done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", int'(start), 0);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(ovr), 0);
    rst_n = 1'b1;

    check("pin_saw", ref_wave(0, 'h1000), 'h100);
    check("pin_tri_peak", ref_wave(1, 'h8000), 'hFFF);
    check("pin_tri_down", ref_wave(1, 'hA000), 'hBFF);
    check("pin_tri_up", ref_wave(1, 'h6000), 'hC00);
    check("pin_square", ref_wave(2, 'hC000), 'hFFF);
    check("pin_dc", ref_wave(3, 'h1234), 'h800);

    // Sawtooth, wrapping after F00
    lat = 70; sel = 2'd0; inc = 16'h1000;
    run_ticks(17);
    check("saw_overrun", int'(ovr), 0);
    stop_and_drain();
    e = '{12'h000, 12'h100, 12'h200, 12'h300, 12'h400, 12'h500, 12'h600, 12'h700,
          12'h800, 12'h900, 12'hA00, 12'hB00, 12'hC00, 12'hD00, 12'hE00, 12'hF00, 12'h000};
    check_seq("saw", e);

    // Triangle
    sel = 2'd1; inc = 16'h2000;
    run_ticks(9);
    stop_and_drain();
    e = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF, 12'h000};
    check_seq("tri", e);

    // Square, then DC selected mid-run
    sel = 2'd2; inc = 16'h4000;
    run_ticks(4);
    sel = 2'd3;
    repeat (3 * DIV) @(negedge clk);
    stop_and_drain();
    e = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h800, 12'h800, 12'h800};
    check_seq("sq_dc", e);

    // Overrun: done slower than the tick period
    lat = 150; sel = 2'd0; inc = 16'h1000;
    run_ticks(6);
    check("ovr_set", int'(ovr), 1);
    stop_and_drain();
    check("ovr_sticky", int'(ovr), 1);
    check("ovr_drained_busy", int'(busy), 0);
    e = '{12'h000, 12'h200, 12'h400};
    check_seq("ovr_skip", e);

    // Done lands on the tick cycle; re-enable clears overrun
    lat = 99;
    cap.delete();
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("reenable_ovr_clear", int'(ovr), 0);
    repeat (5 * DIV - 3) @(negedge clk);
    check("done_on_tick_ovr", int'(ovr), 0);
    stop_and_drain();
    e = '{12'h000, 12'h100, 12'h200, 12'h300, 12'h400};
    check_seq("done_on_tick", e);

    // Disable one cycle after a start
    lat = 70;
    cap.delete();
    en = 1'b1;
    wait_start();
    @(negedge clk);
    en = 1'b0;
    held = cap.size();
    repeat (300) @(negedge clk);
    check("disable_no_start", cap.size(), held);
    check("disable_busy", int'(busy), 0);
    check("disable_data_held", int'(data), 0);

    // Reset mid-frame
    cap.delete();
    en = 1'b1;
    repeat (2 * DIV + 10) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_start", int'(start), 0);
    check("midrst_data", int'(data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(ovr), 0);
    @(negedge clk);
    cap.delete();
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    stop_and_drain();
    e = '{12'h000, 12'h100};
    check_seq("post_reset", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_wave_gen.md
Name: dac_wave_gen

Overview:
Periodic waveform source that sits directly upstream of the DAC121S101 SPI master. It replaces the one-shot ramp sweep for continuous output. A fixed-rate sample timer advances a 16-bit phase accumulator and maps the phase to a 12-bit sawtooth, triangle, square or midscale code. Each sample is handed to the SPI master over its start/done handshake, and any sample tick that arrives while a frame is still in flight is flagged as an overrun.

Parameters:
SAMPLE_DIV, 250, i_Clk cycles per sample tick (25 MHz / 250 = 100 kS/s). Must be >= 80 to cover one SPI frame at CLK_DIV=2 plus its done cycle.
CNT_W, 16, width of the sample-tick counter.

Ports:
i_Clk  in  1  system clock, 25 MHz
i_rst_n  in  1  reset, synchronous, active-low
i_enable  in  1  level; 1 = generate samples
i_wave_sel  in  2  0 saw, 1 triangle, 2 square, 3 midscale DC
i_phase_inc  in  16  phase step per tick; output frequency = Fs*inc/65536
o_dac_start  out  1  one-cycle pulse to the SPI master
o_dac_data  out  12  sample code; held stable from the start pulse until the next start
i_dac_done  in  1  one-cycle pulse from the SPI master, frame complete
o_busy  out  1  SPI frame outstanding (from start until done)
o_overrun  out  1  sticky; a tick arrived while o_busy=1

Behaviour:
- Reset values: o_dac_start=0, o_dac_data=0, o_busy=0, o_overrun=0, phase=0, counter=0, state IDLE.
- States:
  - IDLE -> RUN when i_enable=1. On that transition: phase<=0, counter<=SAMPLE_DIV-1, o_overrun<=0.
  - RUN -> DRAIN when i_enable=0 and o_busy=1.
  - RUN -> IDLE when i_enable=0 and o_busy=0.
  - DRAIN -> IDLE on i_dac_done.
- Counter (RUN only): increments each cycle; tick = (counter==SAMPLE_DIV-1); on tick, counter wraps to 0. First tick therefore occurs on the first RUN cycle.
- On a tick (registered outputs, one cycle latency):
  - Sample is computed from the pre-increment phase p. i_wave_sel and i_phase_inc are sampled in the tick cycle.
  - phase <= p + i_phase_inc, modulo 2^16 (wrap silently).
  - If not busy: o_dac_data <= f(p), o_dac_start=1 next cycle, o_busy <= 1.
  - If busy: no start, o_overrun <= 1, sample dropped; phase still advances.
- Waveform map f(p):
  - saw = p[15:4]
  - tri = p[15] ? ~p[14:3] : p[14:3]
  - square = p[15] ? 12'hFFF : 12'h000
  - DC = 12'h800
- i_dac_done clears o_busy. A done that arrives while o_busy=0 is ignored.
- Same-cycle done and tick: done is applied first, so the tick issues a new start and no overrun is flagged.
- Deassert mid-frame: the in-flight frame completes via DRAIN; no further starts are issued; o_dac_data holds its last value.
- Re-enable: phase restarts at 0.
- Reset mid-frame: everything returns to reset values immediately. The SPI master shares i_rst_n, so no done is expected afterwards.
- o_overrun clears only on reset or on IDLE->RUN.

Test Plan:
1. Sawtooth: SAMPLE_DIV=100, sel=0, inc=16'h1000, SPI model returns done 70 cycles after start -> starts every 100 cycles with data 000,100,200,...,F00,000 (wrap); o_overrun=0.
2. Triangle: sel=1, inc=16'h2000 -> data 000,400,800,C00,FFF,BFF,7FF,3FF, then repeats.
3. Square and DC: sel=2, inc=16'h4000 -> 000,000,FFF,FFF,... Then switch to sel=3 mid-run -> every subsequent sample is 800.
4. Overrun: done latency 150 cycles, SAMPLE_DIV=100 -> o_overrun rises at the 2nd tick and stays high; starts occur only on every other tick; saw values skip (000,200,400,...).
5. Boundaries:
   - done asserted exactly on a tick cycle -> start issued next cycle, o_overrun=0.
   - i_enable dropped one cycle after a start -> no further start, state IDLE after done.
   - Re-enable -> first data 000, o_overrun cleared.
6. Reset: pulse i_rst_n=0 mid-frame -> next cycle all outputs 0, state IDLE; after release with i_enable=1, first sample is phase 0.
